// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci datapath display stage:
// blinker state encodings and default blink timing.
package fib_pkg;

  typedef enum logic [1:0] {
    FIB_BLK_IDLE = 2'd0,
    FIB_BLK_ON   = 2'd1,
    FIB_BLK_OFF  = 2'd2,
    FIB_BLK_GAP  = 2'd3
  } fib_blk_state_e;

  localparam int FIB_ON_CYCLES  = 1600;
  localparam int FIB_OFF_CYCLES = 1600;
  localparam int FIB_GAP_CYCLES = 8000;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times each LED phase; it parks at zero
// until reloaded.
module phase_counter #(
  parameter int CNT_WIDTH = 13
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 load_in,
  input  logic [CNT_WIDTH-1:0] load_value_in,
  output logic                 zero_out
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = load_value_in;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_out = (count_q == '0);

endmodule

// File: rtl/fib_led_blinker.sv
// Shows each accepted value N on one LED as N blinks followed by a dark gap;
// accepts the next value only once the gap has elapsed.
module fib_led_blinker
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 13,
  parameter int ON_CYCLES  = FIB_ON_CYCLES,
  parameter int OFF_CYCLES = FIB_OFF_CYCLES,
  parameter int GAP_CYCLES = FIB_GAP_CYCLES
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  led_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_LOAD = CNT_WIDTH'(OFF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(GAP_CYCLES - 1);

  fib_blk_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] blinks_q, blinks_d;
  logic [DATA_WIDTH-1:0] blinks_dec;
  logic                  ready_q, ready_d;
  logic                  led_q, led_d;
  logic                  done_q, done_d;
  logic                  handshake;
  logic                  cnt_load;
  logic [CNT_WIDTH-1:0]  cnt_load_value;
  logic                  cnt_zero;

  assign handshake  = valid_in && ready_q;
  assign blinks_dec = blinks_q - DATA_WIDTH'(1);

  phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_counter (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .load_in       (cnt_load),
    .load_value_in (cnt_load_value),
    .zero_out      (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    blinks_d       = blinks_q;
    cnt_load       = 1'b0;
    cnt_load_value = ON_LOAD;
    unique case (state_q)
      FIB_BLK_IDLE: begin
        if (handshake) begin
          blinks_d = data_in;
          cnt_load = 1'b1;
          if (data_in != '0) begin
            state_d        = FIB_BLK_ON;
            cnt_load_value = ON_LOAD;
          end else begin
            state_d        = FIB_BLK_GAP;
            cnt_load_value = GAP_LOAD;
          end
        end
      end
      FIB_BLK_ON: begin
        if (cnt_zero) begin
          blinks_d = blinks_dec;
          cnt_load = 1'b1;
          if (blinks_dec == '0) begin
            state_d        = FIB_BLK_GAP;
            cnt_load_value = GAP_LOAD;
          end else begin
            state_d        = FIB_BLK_OFF;
            cnt_load_value = OFF_LOAD;
          end
        end
      end
      FIB_BLK_OFF: begin
        if (cnt_zero) begin
          state_d        = FIB_BLK_ON;
          cnt_load       = 1'b1;
          cnt_load_value = ON_LOAD;
        end
      end
      FIB_BLK_GAP: begin
        if (cnt_zero) begin
          state_d = FIB_BLK_IDLE;
        end
      end
      default: state_d = FIB_BLK_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    ready_d = (state_d == FIB_BLK_IDLE);
    led_d   = (state_d == FIB_BLK_ON);
    done_d  = (state_q != FIB_BLK_IDLE) && (state_d == FIB_BLK_IDLE);
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= FIB_BLK_IDLE;
      blinks_q <= '0;
      ready_q  <= 1'b0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      blinks_q <= blinks_d;
      ready_q  <= ready_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign ready_out = ready_q;
  assign led_out   = led_q;
  assign busy_out  = (state_q != FIB_BLK_IDLE);
  assign done_out  = done_q;

endmodule

// File: tb/tb_fib_led_blinker.sv
// Directed and randomized checks of fib_led_blinker against an expected
// LED waveform built from the blink/gap rules.
module tb_fib_led_blinker;

  localparam int DW  = 4;
  localparam int CW  = 3;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready, led, busy, done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  fib_led_blinker #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock_in  (clk),
    .reset_in  (rst),
    .data_in   (data),
    .valid_in  (valid),
    .ready_out (ready),
    .led_out   (led),
    .busy_out  (busy),
    .done_out  (done)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected LED level for every busy cycle of value v.
  function automatic void build_pattern(input int v);
    exp_q.delete();
    for (int b = 0; b < v; b++) begin
      repeat (ON) exp_q.push_back(1'b1);
      if (b != v - 1) repeat (OFF) exp_q.push_back(1'b0);
    end
    repeat (GAP) exp_q.push_back(1'b0);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_led"}, led, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  task automatic handshake(input int v, input bit keep_valid);
    int w = 0;
    while (ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_hs", ready, 1'b1);
    data  = DW'(v);
    valid = 1'b1;
    tick();
    if (!keep_valid) valid = 1'b0;
  endtask

  // Starts in the cycle after the handshake edge, ends in the done cycle.
  task automatic play(input int v, input bit wiggle);
    int n;
    build_pattern(v);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("led", led, exp_q[i]);
      check("busy", busy, 1'b1);
      check("ready_busy", ready, 1'b0);
      check("done_busy", done, 1'b0);
      tick();
      if (wiggle) data = DW'($urandom);
    end
    check("done_pulse", done, 1'b1);
    check("ready_done", ready, 1'b1);
    check("busy_done", busy, 1'b0);
    check("led_done", led, 1'b0);
    $display("transfer value=%0d busy_cycles=%0d errors=%0d", v, n, errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    #1;
    check("release_ready", ready, 1'b0);
    tick();
    check_idle("first_edge");
    $display("transaction reset_release errors=%0d", errors);

    // No valid: stays idle whatever data does.
    for (int i = 0; i < 8; i++) begin
      data = DW'($urandom);
      tick();
      check_idle("no_valid");
    end
    $display("transaction idle_no_valid errors=%0d", errors);

    handshake(3, 1'b0);
    play(3, 1'b0);

    handshake(0, 1'b0);
    play(0, 1'b0);

    // valid held high: 2 is presented during busy and taken in the done cycle.
    handshake(1, 1'b1);
    data = DW'(2);
    play(1, 1'b0);
    tick();
    valid = 1'b0;
    play(2, 1'b0);

    handshake(15, 1'b0);
    play(15, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int v;
      int gap;
      v   = $urandom_range(0, 15);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("rand_gap");
      end
      handshake(v, 1'b0);
      play(v, 1'b0);
    end

    // Reset on the 2nd cycle of the second ON phase of value 3.
    handshake(3, 1'b0);
    repeat (ON + OFF + 1) tick();
    check("pre_rst_led", led, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_led", led, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    tick();
    check("hold_rst_done", done, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_release_ready", ready, 1'b0);
    tick();
    check_idle("mid_first_edge");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("post_rst");
    end
    $display("transaction reset_mid_operation errors=%0d", errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_led_blinker.md
# fib_led_blinker

Downstream display stage for the Fibonacci datapath. It accepts one DATA_WIDTH-bit result per valid/ready handshake and shows it on a single LED as a pulse train: N blinks for value N, followed by a fixed dark gap that separates consecutive results. The datapath controller presents each result and waits on ready_out before computing the next one.

## Interface
Parameters:
- DATA_WIDTH, 4: width of the displayed value.
- CNT_WIDTH, 13: phase counter width; must hold max(ON_CYCLES, OFF_CYCLES, GAP_CYCLES) - 1.
- ON_CYCLES, 1600: LED-high cycles per blink; must be ≥1.
- OFF_CYCLES, 1600: LED-low cycles between blinks of one value; must be ≥1.
- GAP_CYCLES, 8000: LED-low cycles after the last blink of a value; must be ≥1.

Ports:
- clock_in  input  1  single clock; all state updates on its rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  value to display; sampled only on a handshake.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block is idle and can accept a value; registered.
- led_out  output  1  LED drive, active-high; registered.
- busy_out  output  1  high in every non-IDLE state.
- done_out  output  1  one-cycle pulse on return to IDLE.

## Operation
- FSM states: IDLE, ON, OFF, GAP.
- Registers: a remaining-blinks counter (DATA_WIDTH bits) and a phase down-counter (CNT_WIDTH bits).
- Handshake: a value is accepted on the rising edge where valid_in && ready_out.
  - data_in is captured into the remaining-blinks counter.
  - ready_out clears on the same edge.
  - valid_in and data_in are ignored while ready_out is 0.
- IDLE → ON on a handshake with data_in ≠ 0. The phase counter loads ON_CYCLES-1.
- IDLE → GAP on a handshake with data_in = 0. The phase counter loads GAP_CYCLES-1 and the LED stays dark.
- ON, when the phase counter = 0:
  - The remaining-blinks counter decrements.
  - If the decremented value is 0: → GAP, counter loads GAP_CYCLES-1.
  - Otherwise: → OFF, counter loads OFF_CYCLES-1.
- OFF → ON when the phase counter = 0; counter loads ON_CYCLES-1.
- GAP → IDLE when the phase counter = 0. On that edge ready_out sets and done_out pulses.
- Outputs per state:
  - led_out = 1 only in ON.
  - busy_out = (state ≠ IDLE).
- Arithmetic is unsigned. The maximum value 2^DATA_WIDTH-1 gives 15 blinks; there is no wrap-around.

## Timing
- Reset values: state IDLE, led_out 0, ready_out 0, busy_out 0, done_out 0, both counters 0.
- After reset deasserts, ready_out goes to 1 on the first rising edge.
- Latency: led_out is 1 in the cycle right after the handshake edge.
- Busy duration for value N ≥ 1 is N·ON_CYCLES + (N−1)·OFF_CYCLES + GAP_CYCLES cycles. For N = 0 it is GAP_CYCLES cycles.
- done_out is high for exactly one cycle: the first cycle of IDLE, when ready_out = 1.
- Back-to-back transfers: a handshake is legal in the done_out cycle. The new value is accepted at the end of that cycle with no dead cycle.
- Reset mid-operation: led_out, busy_out and ready_out drop to 0 immediately (asynchronous). The in-flight value is discarded and no done_out pulse is generated.
- A valid_in that is held during busy has no effect. The value present on data_in at the first ready_out cycle is the one accepted.

## Structure
- Shared package fib_pkg holds:
  - state encodings FIB_BLK_IDLE/ON/OFF/GAP (2-bit);
  - default timing constants FIB_ON_CYCLES = 1600, FIB_OFF_CYCLES = 1600, FIB_GAP_CYCLES = 8000.
- Sub-module phase_counter holds the CNT_WIDTH-bit down-counter. Ports: clock_in, reset_in, load_in, load_value_in, zero_out. The FSM and handshake logic stay in fib_led_blinker.

## Test plan
All scenarios use ON_CYCLES = 3, OFF_CYCLES = 2, GAP_CYCLES = 5, CNT_WIDTH = 3.
- Value 3 accepted → led_out pattern 111 00 111 00 111, then 5 low cycles. busy_out is high for 18 cycles, then one done_out pulse with ready_out = 1.
- Value 0 accepted → led_out never rises. busy_out is high for 5 cycles, then done_out.
- valid_in held high with values 1 then 2 presented back-to-back → the second value is accepted in the first done_out cycle. Then 1 blink + gap (8 cycles) followed by 2 blinks + gap (13 cycles).
- Value 15 accepted → 15 blinks, busy for 78 cycles. data_in toggled during busy has no effect.
- reset_in asserted on the 2nd cycle of the second ON phase → led_out is 0 immediately and no done_out is produced. After release, ready_out = 0 until the first edge, then 1.
- valid_in = 0 → ready_out stays 1, led_out 0, busy_out 0 indefinitely.
